// File: rtl/bm_scheduler_pkg.sv
// Shared definitions for the Berlekamp-Massey request scheduler.
//   - FSM state encoding
//   - default T_MAX / M_MAX and the derived operand widths
//     (SYN_W = 2*T_MAX*M_MAX, SIG_W = (T_MAX+1)*M_MAX)
//   - legal symbol-width bounds (M_MIN = 3 up to the M_MAX parameter)
// No ports.
package bm_scheduler_pkg;

    localparam int T_MAX_DEF = 4;
    localparam int M_MAX_DEF = 10;
    localparam int M_MIN     = 3;

    localparam int SYN_W = 2 * T_MAX_DEF * M_MAX_DEF;
    localparam int SIG_W = (T_MAX_DEF + 1) * M_MAX_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } bm_state_e;

    // Width helpers for non-default T_MAX / M_MAX instances.
    function automatic int syn_w(input int t_max, input int m_max);
        return 2 * t_max * m_max;
    endfunction

    function automatic int sig_w(input int t_max, input int m_max);
        return (t_max + 1) * m_max;
    endfunction

endpackage

// File: rtl/bm_scheduler_rr_arb.sv
// Two-way round-robin arbiter for the scheduler.
// Ports:
//   req   [1:0] in  - request lines
//   ptr         in  - preferred requester
//   grant [1:0] out - one-hot grant, or zero when nobody requests
module bm_rr_arb
    import bm_scheduler_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    logic w_other;

    assign w_other = ~ptr;

    always_comb begin
        grant = 2'b00;
        if (req[ptr]) begin
            grant[ptr] = 1'b1;
        end else if (req[w_other]) begin
            grant[w_other] = 1'b1;
        end
    end

endmodule

// File: rtl/bm_scheduler.sv
// Scheduler sharing one Berlekamp-Massey core between two requesters.
// Grants one request at a time (round-robin), checks t/m, launches the core
// with a one-cycle bm_start, collects its result and holds it on rsp_* until
// rsp_ready.
// Ports:
//   clk, rstn                         clock, async active-low reset
//   req_valid/req_ready [1:0]         per-requester handshake
//   req_t/req_m [7:0]                 t and m, requester 0 in LSBs
//   req_syn [2*SYN_W-1:0]             syndromes, requester 0 in LSBs
//   bm_start, bm_t, bm_m, bm_syndromes  core launch and registered operands
//   bm_done, bm_failure, bm_degree, bm_sigma  core result
//   rsp_valid/rsp_ready               result handshake
//   rsp_id, rsp_failure, rsp_degree, rsp_sigma  result payload
// Optional feature: BM_SCHED_ZERO_BYPASS_EN answers all-zero syndromes with
// sigma = 1 directly, without running the core.
module bm_scheduler
    import bm_scheduler_pkg::*;
#(
    parameter int T_MAX = T_MAX_DEF,
    parameter int M_MAX = M_MAX_DEF
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [1:0]                            req_valid,
    output logic [1:0]                            req_ready,
    input  logic [7:0]                            req_t,
    input  logic [7:0]                            req_m,
    input  logic [2*syn_w(T_MAX, M_MAX)-1:0]      req_syn,
    output logic                                  bm_start,
    output logic [3:0]                            bm_t,
    output logic [3:0]                            bm_m,
    output logic [syn_w(T_MAX, M_MAX)-1:0]        bm_syndromes,
    input  logic                                  bm_done,
    input  logic                                  bm_failure,
    input  logic [3:0]                            bm_degree,
    input  logic [sig_w(T_MAX, M_MAX)-1:0]        bm_sigma,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic                                  rsp_id,
    output logic                                  rsp_failure,
    output logic [3:0]                            rsp_degree,
    output logic [sig_w(T_MAX, M_MAX)-1:0]        rsp_sigma
);

    localparam int LP_SYN_W = syn_w(T_MAX, M_MAX);
    localparam int LP_SIG_W = sig_w(T_MAX, M_MAX);
    localparam logic [LP_SIG_W-1:0] LP_SIGMA_ONE = LP_SIG_W'(1);

    bm_state_e             r_state;
    bm_state_e             w_state_nxt;
    logic                  r_rr;
    logic [3:0]            r_bm_t;
    logic [3:0]            r_bm_m;
    logic [LP_SYN_W-1:0]   r_bm_syn;
    logic                  r_rsp_id;
    logic                  r_rsp_failure;
    logic [3:0]            r_rsp_degree;
    logic [LP_SIG_W-1:0]   r_rsp_sigma;

    logic [1:0]            w_arb_grant;
    logic [1:0]            w_grant;
    logic                  w_sel;
    logic [3:0]            w_t;
    logic [3:0]            w_m;
    logic [LP_SYN_W-1:0]   w_syn;
    logic                  w_params_ok;
    logic                  w_bypass;
    logic                  w_bm_start;
    logic                  w_rsp_valid;

    bm_rr_arb u_arb (
        .req   (req_valid),
        .ptr   (r_rr),
        .grant (w_arb_grant)
    );

    // Grants only happen in IDLE, so a response handshake cycle (RESP) can
    // never coincide with a new grant.
    assign w_grant   = (r_state == ST_IDLE) ? w_arb_grant : 2'b00;
    assign req_ready = w_grant;
    assign w_sel     = w_grant[1];

    assign w_t   = w_sel ? req_t[7:4] : req_t[3:0];
    assign w_m   = w_sel ? req_m[7:4] : req_m[3:0];
    assign w_syn = w_sel ? req_syn[2*LP_SYN_W-1:LP_SYN_W] : req_syn[LP_SYN_W-1:0];

    assign w_params_ok = (w_t != 4'd0) && (int'(w_t) <= T_MAX) &&
                         (int'(w_m) >= M_MIN) && (int'(w_m) <= M_MAX);

`ifdef BM_SCHED_ZERO_BYPASS_EN
    assign w_bypass = w_params_ok && (w_syn == '0);
`else
    assign w_bypass = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bm_start  = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_grant) begin
                    w_state_nxt = (!w_params_ok || w_bypass) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_bm_start  = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bm_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr          <= 1'b0;
            r_bm_t        <= '0;
            r_bm_m        <= '0;
            r_bm_syn      <= '0;
            r_rsp_id      <= 1'b0;
            r_rsp_failure <= 1'b0;
            r_rsp_degree  <= '0;
            r_rsp_sigma   <= '0;
        end else begin
            if (|w_grant) begin
                r_rr          <= ~w_sel;
                r_bm_t        <= w_t;
                r_bm_m        <= w_m;
                r_bm_syn      <= w_syn;
                r_rsp_id      <= w_sel;
                // Preload the answer for the skip-core paths; the core path
                // overwrites it when bm_done arrives.
                r_rsp_failure <= ~w_params_ok;
                r_rsp_degree  <= '0;
                r_rsp_sigma   <= w_bypass ? LP_SIGMA_ONE : '0;
            end
            if ((r_state == ST_WAIT) && bm_done) begin
                r_rsp_failure <= bm_failure;
                r_rsp_degree  <= bm_degree;
                r_rsp_sigma   <= bm_sigma;
            end
        end
    end

    assign bm_start     = w_bm_start;
    assign bm_t         = r_bm_t;
    assign bm_m         = r_bm_m;
    assign bm_syndromes = r_bm_syn;
    assign rsp_valid    = w_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_failure  = r_rsp_failure;
    assign rsp_degree   = r_rsp_degree;
    assign rsp_sigma    = r_rsp_sigma;

endmodule

// File: tb/tb_bm_scheduler.sv
// Scoreboard bench for bm_scheduler with a behavioural Berlekamp core stub
// (bm_done five cycles after bm_start).
module tb_bm_scheduler;

    localparam int SYN_W = 80;
    localparam int SIG_W = 50;

    typedef struct packed {
        logic             id;
        logic             fail;
        logic [3:0]       deg;
        logic [SIG_W-1:0] sig;
    } rsp_t;

    logic               clk;
    logic               rstn;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [7:0]         req_t;
    logic [7:0]         req_m;
    logic [2*SYN_W-1:0] req_syn;
    logic               bm_start;
    logic [3:0]         bm_t;
    logic [3:0]         bm_m;
    logic [SYN_W-1:0]   bm_syndromes;
    logic               bm_done;
    logic               core_fail;
    logic [3:0]         core_deg;
    logic [SIG_W-1:0]   core_sig;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic               rsp_failure;
    logic [3:0]         rsp_degree;
    logic [SIG_W-1:0]   rsp_sigma;

    int   n_chk;
    int   n_fail;
    int   n_start;
    bit   stub_en;
    int   stray_cnt;
    rsp_t exp_q[$];

    bm_scheduler #(.T_MAX(4), .M_MAX(10)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_t        (req_t),
        .req_m        (req_m),
        .req_syn      (req_syn),
        .bm_start     (bm_start),
        .bm_t         (bm_t),
        .bm_m         (bm_m),
        .bm_syndromes (bm_syndromes),
        .bm_done      (bm_done),
        .bm_failure   (core_fail),
        .bm_degree    (core_deg),
        .bm_sigma     (core_sig),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_failure  (rsp_failure),
        .rsp_degree   (rsp_degree),
        .rsp_sigma    (rsp_sigma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic rsp_t model(input logic id, input logic [3:0] t, input logic [3:0] m,
                                   input logic [SYN_W-1:0] syn);
        rsp_t r;
        r.id = id;
        if (t == 4'd0 || t > 4'd4 || m < 4'd3 || m > 4'd10) begin
            r.fail = 1'b1; r.deg = 4'd0; r.sig = '0;
        end
`ifdef BM_SCHED_ZERO_BYPASS_EN
        else if (syn == '0) begin
            r.fail = 1'b0; r.deg = 4'd0; r.sig = SIG_W'(1);
        end
`endif
        else begin
            r.fail = core_fail; r.deg = core_deg; r.sig = core_sig;
        end
        return r;
    endfunction

    task automatic start_req(input int who, input logic [3:0] t, input logic [3:0] m,
                             input logic [SYN_W-1:0] syn, input bit push);
        req_t[who*4 +: 4]         = t;
        req_m[who*4 +: 4]         = m;
        req_syn[who*SYN_W +: SYN_W] = syn;
        req_valid[who]            = 1'b1;
        if (push) exp_q.push_back(model(who[0], t, m, syn));
    endtask

    task automatic wait_grant(input logic [1:0] exp_g, input string tag);
        int k;
        logic [1:0] g;
        k = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && k < 100) begin
            @(negedge clk);
            k++;
        end
        g = req_ready;
        chk(tag, g, exp_g);
        @(posedge clk);
        #1 req_valid = req_valid & ~g;
    endtask

    task automatic wait_rsp(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 100);
        if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
    endtask

    // Core stub and stray-done injector (sole driver of bm_done).
    initial begin
        int stray_seen;
        stray_seen = 0;
        bm_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bm_start && stub_en) begin
                repeat (5) @(posedge clk);
                #1 bm_done = 1'b1;
                @(posedge clk);
                #1 bm_done = 1'b0;
            end else if (stray_seen != stray_cnt) begin
                stray_seen++;
                @(posedge clk);
                #1 bm_done = 1'b1;
                @(posedge clk);
                #1 bm_done = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every handshake.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bm_start) n_start++;
            if (rstn && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_failure", rsp_failure, e.fail);
                    chk("rsp_degree", rsp_degree, e.deg);
                    chk("rsp_sigma", rsp_sigma, e.sig);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rsp_t e_hold;
        logic [SYN_W-1:0] syn_a, syn_b, syn_c;
        syn_a = 80'h1234_5678_9ABC_DEF0_1357;
        syn_b = 80'h0F0E_0D0C_0B0A_0908_0706;
        syn_c = 80'h8000_0000_0000_0000_0001;
        n_chk = 0; n_fail = 0; n_start = 0; stray_cnt = 0; stub_en = 1'b1;
        rstn = 1'b0; req_valid = 2'b00; req_t = '0; req_m = '0; req_syn = '0;
        rsp_ready = 1'b1; core_fail = 1'b0; core_deg = 4'd2; core_sig = 50'h2_3456_789A_BCDE;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {rsp_valid, bm_start, req_ready}, 4'b0000);
        chk("rst_ops", {bm_t, bm_m, bm_syndromes}, '0);
        chk("rst_payload", {rsp_id, rsp_failure, rsp_degree, rsp_sigma}, '0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Both requesters: 0 first, then 1; core latency 5 -> 7 cycles
        @(posedge clk);
        #1 n_start = 0;
        start_req(0, 4'd2, 4'd8, syn_a, 1'b1);
        start_req(1, 4'd3, 4'd5, syn_b, 1'b1);
        wait_grant(2'b01, "grant_first");
        wait_rsp(k);
        chk("lat_core_0", k, 7);
        chk("busy_ready", req_ready, 2'b00);
        chk("ops_held", {bm_t, bm_m, bm_syndromes}, {4'd2, 4'd8, syn_a});
        wait_grant(2'b10, "grant_second");
        wait_rsp(k);
        chk("lat_core_1", k, 7);
        chk("ops_req1", {bm_t, bm_m, bm_syndromes}, {4'd3, 4'd5, syn_b});
        @(posedge clk);
        #1 chk("start_pulses", n_start, 2);

        // Illegal parameters skip the core
        n_start = 0;
        start_req(0, 4'd5, 4'd8, syn_a, 1'b1);
        wait_grant(2'b01, "grant_bad_t");
        wait_rsp(k);
        chk("lat_bad_t", k, 1);
        start_req(1, 4'd2, 4'd11, syn_b, 1'b1);
        wait_grant(2'b10, "grant_bad_m");
        wait_rsp(k);
        start_req(0, 4'd2, 4'd2, syn_b, 1'b1);
        wait_grant(2'b01, "grant_small_m");
        wait_rsp(k);
        @(posedge clk);
        #1 chk("illegal_no_start", n_start, 0);

        // Backpressure with a pending zero-syndrome request behind it
        core_deg = 4'd3; core_sig = 50'h1_0203_0405_0607; core_fail = 1'b1;
        rsp_ready = 1'b0;
        n_start = 0;
        e_hold = model(1'b1, 4'd4, 4'd10, syn_c);
        start_req(1, 4'd4, 4'd10, syn_c, 1'b1);
        wait_grant(2'b10, "grant_hold");
        wait_rsp(k);
        @(posedge clk);
        #1 start_req(0, 4'd2, 4'd4, '0, 1'b1);
        repeat (10) begin
            @(negedge clk);
            chk("hold", {rsp_valid, req_ready, rsp_id, rsp_failure, rsp_degree, rsp_sigma},
                {1'b1, 2'b00, e_hold.id, e_hold.fail, e_hold.deg, e_hold.sig});
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_grant(2'b01, "grant_zero_syn");
        wait_rsp(k);
`ifdef BM_SCHED_ZERO_BYPASS_EN
        chk("lat_zero_syn", k, 1);
        @(posedge clk);
        #1 chk("zero_syn_starts", n_start, 1);
`else
        chk("lat_zero_syn", k, 7);
        @(posedge clk);
        #1 chk("zero_syn_starts", n_start, 2);
`endif

        // Reset while waiting on the core, then a stray bm_done
        stub_en = 1'b0;
        core_fail = 1'b0;
        start_req(1, 4'd2, 4'd6, syn_a, 1'b0);
        wait_grant(2'b10, "grant_abandon");
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_ctrl", {rsp_valid, bm_start, req_ready}, 4'b0000);
        chk("mid_rst_ops", {bm_t, bm_m, bm_syndromes}, '0);
        chk("mid_rst_payload", {rsp_id, rsp_failure, rsp_degree, rsp_sigma}, '0);
        @(posedge clk);
        #1 rstn = 1'b1;
        stray_cnt++;
        repeat (4) begin
            @(negedge clk);
            chk("stray_quiet", {rsp_valid, bm_start}, 2'b00);
        end

        // rr pointer back to 0 after reset
        @(posedge clk);
        #1 stub_en = 1'b1;
        start_req(0, 4'd4, 4'd3, syn_b, 1'b1);
        start_req(1, 4'd1, 4'd9, syn_c, 1'b1);
        wait_grant(2'b01, "grant_post_rst_0");
        wait_rsp(k);
        wait_grant(2'b10, "grant_post_rst_1");
        wait_rsp(k);
        @(posedge clk);
        #1 chk("q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bm_scheduler.md
BM_SCHEDULER -- requirements
Module: bm_scheduler

Interface
REQ-001 SHALL have parameter T_MAX, default 4, max correctable errors; sets syndrome and sigma widths.
REQ-002 SHALL have parameter M_MAX, default 10, max GF(2^m) symbol width in bits.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  2  per-requester request strobe.
REQ-006 SHALL have port req_ready  out  2  per-requester accept, one-hot or zero.
REQ-007 SHALL have port req_t / req_m  in  2x4 each  packed per requester, requester 0 in LSBs.
REQ-008 SHALL have port req_syn  in  2x(2*T_MAX*M_MAX)  packed syndromes, requester 0 in LSBs.
REQ-009 SHALL have port bm_start  out  1  one-cycle start pulse to the shared Berlekamp core.
REQ-010 SHALL have port bm_t / bm_m / bm_syndromes  out  4 / 4 / 2*T_MAX*M_MAX  registered core operands.
REQ-011 SHALL have port bm_done, bm_failure, bm_degree, bm_sigma  in  1 / 1 / 4 / (T_MAX+1)*M_MAX  core results.
REQ-012 SHALL have port rsp_valid, rsp_ready  out/in  1 each  result handshake.
REQ-013 SHALL have port rsp_id, rsp_failure, rsp_degree, rsp_sigma  out  1 / 1 / 4 / (T_MAX+1)*M_MAX  result payload.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-015 In IDLE with any req_valid, SHALL grant one requester, drive req_ready for it that cycle, capture id/t/m/syn, and go to ISSUE.
REQ-016 Arbitration SHALL be round-robin: rr pointer names the preferred requester, and the other is granted only if the preferred one is idle.
REQ-017 The rr pointer SHALL move to the non-granted requester on each grant.
REQ-018 req_ready SHALL be zero outside IDLE and SHALL depend only on state, req_valid and the rr pointer.
REQ-019 Parameter check at capture: if t==0, t>T_MAX, m<3 or m>M_MAX, SHALL skip the core and go to RESP with rsp_failure=1, rsp_degree=0, rsp_sigma=0.
REQ-020 ISSUE SHALL assert bm_start for exactly one cycle with bm_* operands stable, then go to WAIT.
REQ-021 bm_t, bm_m and bm_syndromes SHALL hold their values from ISSUE until the next grant.
REQ-022 In WAIT, on bm_done, SHALL register failure, degree and sigma into the rsp_* outputs and go to RESP.
REQ-023 bm_done outside WAIT SHALL be ignored.
REQ-024 RESP SHALL hold rsp_valid=1 with a stable payload until rsp_ready.
REQ-025 On the rsp_valid&&rsp_ready cycle, SHALL go to IDLE.
REQ-026 A new grant SHALL NOT occur in the same cycle as a response handshake.
REQ-027 Minimum grant-to-rsp_valid latency SHALL be 2 cycles plus the core latency (grant, ISSUE, WAIT until bm_done, rsp_valid next cycle).
REQ-028 Requests whose valid drops before grant SHALL be ignored; no request queueing.

Reset
REQ-029 On rstn low: state IDLE, rr pointer 0, bm_start 0, req_ready 0, rsp_valid 0, and all registered payloads and operands 0.
REQ-030 Reset mid-operation SHALL abandon the transaction with no response issued.

Configuration
REQ-031 SHALL provide compile macro BM_SCHED_ZERO_BYPASS_EN.
REQ-032 With BM_SCHED_ZERO_BYPASS_EN defined: if the captured syndromes are all zero and the parameters are legal, SHALL skip ISSUE/WAIT and enter RESP with rsp_failure=0, rsp_degree=0, rsp_sigma = sigma_0=1, others 0.
REQ-033 Without BM_SCHED_ZERO_BYPASS_EN: all-zero syndromes SHALL go through the core like any other request.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding, the widths SYN_W=2*T_MAX*M_MAX and SIG_W=(T_MAX+1)*M_MAX, and the legal m bounds (3, M_MAX).
REQ-035 The round-robin 2-way arbiter SHALL be one sub-module, bm_rr_arb (inputs req, ptr; output one-hot grant).

Verification
REQ-036 Both req_valid=1 after reset: requester 0 granted first (req_ready=01), then requester 1 after its response; rsp_id 0 then 1.
REQ-037 Core stub with bm_done 5 cycles after start, degree=2, sigma=0x...: rsp_valid seen 7 cycles after grant with matching payload; bm_start high exactly 1 cycle.
REQ-038 req_t=5 with T_MAX=4: no bm_start; rsp_failure=1, degree 0, sigma 0.
REQ-039 rsp_ready held 0 for 10 cycles: rsp_valid and payload stable, req_ready stays 00 despite pending req_valid.
REQ-040 All-zero syndromes: with macro, no bm_start and sigma_0=1, degree 0; without macro, bm_start pulses.
REQ-041 rstn asserted in WAIT, then stray bm_done: outputs at reset values, no rsp_valid.
